mem_latency_model: RTL and testbench
====================================

Name: mem_latency_model

Overview:
Word-addressed main-memory slave that sits directly downstream of the instruction/data cache miss path. It serves the cache's single-word Allocate reads and WriteBack writes over the valid/ready memory handshake. Responses arrive after a fixed, parameterised latency, so the cache FSM sees realistic multi-cycle misses. Two per-type transaction counters support cache hit/miss performance checks.

Parameters:
ADDR_WIDTH, 10, number of word-index bits; depth = 2**ADDR_WIDTH words of 32 bits.
LATENCY, 4, number of cycles from request acceptance to the ready pulse; legal range 1..15.

Ports:
clk  input  1  clock.
rst  input  1  reset; synchronous, active-high.
mem_req_addr  input  32  byte address; bits [1:0] ignored; word index = addr[ADDR_WIDTH+1:2]; upper bits ignored, so the address wraps.
mem_req_valid  input  1  request valid; held high by the requester until it sees ready.
mem_req_wr  input  1  1 = write, 0 = read; sampled at acceptance.
mem_wr_data  input  32  write data; sampled at acceptance.
mem_req_data  output  32  read data; valid in the ready cycle of a read.
mem_req_ready  output  1  one-cycle completion pulse.
rd_count  output  32  number of completed reads.
wr_count  output  32  number of completed writes.

Behaviour:
- Reset values: state IDLE; mem_req_ready=0; mem_req_data=0; rd_count=0; wr_count=0; latency counter=0.
- Memory array is zero-initialised at time 0 and is not cleared by rst.
- All outputs are registered.
- FSM states and transitions:
  - IDLE: if mem_req_valid=1, accept the request. Capture word index, wr and wr_data; load counter with LATENCY-1; go to BUSY. If LATENCY=1, go directly to RESP.
  - BUSY: decrement the counter each cycle. When the counter reaches 0, go to RESP. mem_req_valid is ignored here; the requester keeps it high.
  - RESP: mem_req_ready=1 for exactly this cycle.
    - Read: mem_req_data = mem[captured index], registered on entry to RESP.
    - Write: mem_req_data holds its previous value; mem[index] <= captured data at the clock edge that leaves RESP.
    - At that same edge, increment rd_count or wr_count (both wrap at 2**32).
    - Next state is always IDLE.
- Timing: the acceptance cycle is cycle 0; mem_req_ready is high in cycle LATENCY. A new request is accepted no earlier than cycle LATENCY+1.
- Requester rule: valid must drop in the cycle after ready. If valid is still high in IDLE, it is treated as a new request; the bench flags this as a protocol error.
- Captured fields are used for the whole transaction. Changes on addr, wr or wr_data after acceptance have no effect.
- A read issued after a write to the same address returns the new data.
- mem_req_data is not cleared between transactions. Read data holds until the next read response.
- rst asserted in any state: next cycle is IDLE with ready=0 and counters cleared. An in-flight write is abandoned and memory is not modified. A pending read produces no ready pulse.

Optional Feature:
MEM_RAND_LAT_EN
- Defined:
  - Adds an 8-bit Fibonacci LFSR, taps 8,6,5,4; reset seed 8'hA5; advances every cycle while not in reset.
  - At acceptance, extra = lfsr[1:0].
  - The counter loads LATENCY-1+extra, so ready occurs in cycle LATENCY+extra, i.e. LATENCY..LATENCY+3.
  - All other behaviour is unchanged.
- Undefined: no LFSR logic is present; latency is exactly LATENCY.

Test Plan:
1. LATENCY=4, reset, then read addr 0x0000_0010 -> ready high in exactly cycle 4 only; mem_req_data=0x0000_0000; rd_count=1.
2. Write 0x0000_0010 data 0xDEAD_BEEF, then read 0x0000_0010 -> write ready in cycle 4; read returns 0xDEAD_BEEF; wr_count=1; rd_count=1.
3. ADDR_WIDTH=10: write 0x0000_1004 data 0x1234_5678, then read 0x0000_0004 -> returns 0x1234_5678 (address wrap); low address bits 2'b11 are ignored.
4. Assert rst in cycle 2 of a write to 0x20 with data 0xAAAA_5555 -> no ready pulse; counters=0; a later read of 0x20 returns 0x0000_0000.
5. Change addr and wr_data during BUSY (0x30 -> 0x40, 0x1 -> 0x2) on a write -> only mem[0x30>>2] is written, with 0x1; mem[0x40>>2] is unchanged.
6. MEM_RAND_LAT_EN defined, 16 back-to-back reads -> every ready occurs in cycles 4..7 after acceptance; the sequence matches the reference LFSR from seed 0xA5; rd_count=16.

Source files
------------

// File: rtl/mem_latency_model.sv
// mem_latency_model: word-addressed 32-bit main-memory slave for the cache miss path.
// Each request is accepted, then answered after a fixed latency with one-cycle ready
// pulse. Separate counters track completed reads and writes.
//
// Optional build macro MEM_RAND_LAT_EN: adds an 8-bit LFSR (taps 8,6,5,4, seed 8'hA5)
// whose low two bits, sampled at acceptance, add 0..3 extra cycles of latency.
//
// Handshake: the requester raises mem_req_valid with addr/wr/wr_data and holds it until
// it sees mem_req_ready; ready is a single-cycle completion pulse, and valid must be
// low in the cycle after ready, otherwise it is taken as a fresh request.

module mem_latency_model #(
    parameter int ADDR_WIDTH = 10,
    parameter int LATENCY    = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] mem_req_addr,
    input  logic        mem_req_valid,
    input  logic        mem_req_wr,
    input  logic [31:0] mem_wr_data,
    output logic [31:0] mem_req_data,
    output logic        mem_req_ready,
    output logic [31:0] rd_count,
    output logic [31:0] wr_count,
    output logic [1:0]  fsm_state
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [4:0] LAT_M1 = 5'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic [4:0]              cnt;
    logic [4:0]              cnt_next;
    logic [4:0]              extra;
    logic [4:0]              load_val;
    logic                    accept;
    logic [ADDR_WIDTH-1:0]   req_idx;
    logic [ADDR_WIDTH-1:0]   idx_q;
    logic                    wr_q;
    logic [31:0]             wdata_q;
    logic [ADDR_WIDTH-1:0]   cur_idx;
    logic                    cur_wr;

    // Memory starts at zero and deliberately survives rst.
    logic [31:0] mem [DEPTH] = '{default: '0};

    // Byte-offset bits and bits above the word index are ignored, so addresses wrap.
    logic unused_addr;
    assign unused_addr = ^{mem_req_addr[31:ADDR_WIDTH+2], mem_req_addr[1:0]};
    assign req_idx     = mem_req_addr[ADDR_WIDTH+1:2];

`ifdef MEM_RAND_LAT_EN
    logic [7:0] lfsr;

    // Free-running Fibonacci LFSR supplying 0..3 extra cycles per transaction.
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr <= 8'hA5;
        end else begin
            lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        end
    end

    assign extra = {3'b000, lfsr[1:0]};
`else
    assign extra = 5'd0;
`endif

    assign load_val  = LAT_M1 + extra;
    assign fsm_state = state;

    // When going straight from IDLE to RESP the captured fields are not yet
    // registered, so the read path takes them from the live request.
    assign cur_idx = (state == IDLE) ? req_idx : idx_q;
    assign cur_wr  = (state == IDLE) ? mem_req_wr : wr_q;

    // State and latency counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 5'd0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Next-state logic: accept in IDLE, count down in BUSY, single RESP cycle.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (mem_req_valid) begin
                    accept     = 1'b1;
                    cnt_next   = load_val;
                    state_next = (load_val == 5'd0) ? RESP : BUSY;
                end
            end
            BUSY: begin
                cnt_next = cnt - 5'd1;
                if (cnt == 5'd1) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
                cnt_next   = 5'd0;
            end
        endcase
    end

    // Capture the request fields once; later changes on the inputs are ignored.
    always_ff @(posedge clk) begin
        if (!rst && accept) begin
            idx_q   <= req_idx;
            wr_q    <= mem_req_wr;
            wdata_q <= mem_wr_data;
        end
    end

    // Registered outputs: ready pulse, read data on RESP entry, counters on RESP exit.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_req_ready <= 1'b0;
            mem_req_data  <= 32'd0;
            rd_count      <= 32'd0;
            wr_count      <= 32'd0;
        end else begin
            mem_req_ready <= (state_next == RESP);
            if (state_next == RESP && !cur_wr) begin
                mem_req_data <= mem[cur_idx];
            end
            if (state == RESP) begin
                if (wr_q) begin
                    wr_count <= wr_count + 32'd1;
                end else begin
                    rd_count <= rd_count + 32'd1;
                end
            end
        end
    end

    // Writes commit at the edge leaving RESP; a reset there abandons the write.
    always_ff @(posedge clk) begin
        if (!rst && state == RESP && wr_q) begin
            mem[idx_q] <= wdata_q;
        end
    end

endmodule

// File: tb/tb_mem_latency_model.sv
// Self-checking bench for mem_latency_model: table of directed transactions plus
// hand-written sequences for reset mid-write, input changes during BUSY and a run of
// sixteen reads. Build with +define+MEM_RAND_LAT_EN to check the random-latency build.

module tb_mem_latency_model;

    localparam int AW  = 10;
    localparam int LAT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] mem_req_addr;
    logic        mem_req_valid;
    logic        mem_req_wr;
    logic [31:0] mem_wr_data;
    logic [31:0] mem_req_data;
    logic        mem_req_ready;
    logic [31:0] rd_count;
    logic [31:0] wr_count;
    logic [1:0]  fsm_state;

    int n_checks = 0;
    int n_pass   = 0;

    mem_latency_model #(.ADDR_WIDTH(AW), .LATENCY(LAT)) dut (
        .clk           (clk),
        .rst           (rst),
        .mem_req_addr  (mem_req_addr),
        .mem_req_valid (mem_req_valid),
        .mem_req_wr    (mem_req_wr),
        .mem_wr_data   (mem_wr_data),
        .mem_req_data  (mem_req_data),
        .mem_req_ready (mem_req_ready),
        .rd_count      (rd_count),
        .wr_count      (wr_count),
        .fsm_state     (fsm_state)
    );

    // Clock and reset block.
    always #5 clk = ~clk;

`ifdef MEM_RAND_LAT_EN
    // Reference LFSR, stepped independently of the DUT.
    logic [7:0] m_lfsr;
    always @(posedge clk) begin
        if (rst) m_lfsr <= 8'hA5;
        else     m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    end
`endif

    function automatic int exp_lat();
`ifdef MEM_RAND_LAT_EN
        return LAT + int'(m_lfsr[1:0]);
`else
        return LAT;
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // Driver: one transaction; returns read data seen at ready and the observed latency.
    task automatic run_txn(input logic w, input logic [31:0] a, input logic [31:0] d,
                           input bit mutate, output logic [31:0] rdata);
        int lat;
        int elat;
        @(negedge clk);
        mem_req_valid = 1'b1;
        mem_req_wr    = w;
        mem_req_addr  = a;
        mem_wr_data   = d;
        elat          = exp_lat();
        lat           = 0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (mutate && n == 1) begin
                mem_req_addr = a + 32'h10;
                mem_wr_data  = d + 32'd1;
                mem_req_wr   = ~w;
            end
            if (mem_req_ready) begin
                lat = n;
                break;
            end
        end
        mem_req_valid = 1'b0;
        mem_req_wr    = 1'b0;
        rdata         = mem_req_data;
        check("latency", lat, elat);
        @(negedge clk);
        check("ready_one_cycle", {31'd0, mem_req_ready}, 32'd0);
    endtask

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] exp_data;
        logic [31:0] exp_rd;
        logic [31:0] exp_wr;
    } vec_t;

    vec_t        vecs[8];
    logic [31:0] rdata;
    int          pulses;

    initial begin
        // Reads return mem contents; writes leave the last read data on the bus.
        vecs[0] = '{1'b0, 32'h0000_0010, 32'h0,         32'h0000_0000, 32'd1, 32'd0};
        vecs[1] = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0000, 32'd1, 32'd1};
        vecs[2] = '{1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 32'd2, 32'd1};
        vecs[3] = '{1'b1, 32'h0000_1004, 32'h1234_5678, 32'hDEAD_BEEF, 32'd2, 32'd2};
        vecs[4] = '{1'b0, 32'h0000_0007, 32'h0,         32'h1234_5678, 32'd3, 32'd2};
        vecs[5] = '{1'b0, 32'h0000_0004, 32'h0,         32'h1234_5678, 32'd4, 32'd2};
        vecs[6] = '{1'b1, 32'h0000_0000, 32'hCAFE_F00D, 32'h1234_5678, 32'd4, 32'd3};
        vecs[7] = '{1'b0, 32'hFFFF_F000, 32'h0,         32'hCAFE_F00D, 32'd5, 32'd3};

        rst           = 1'b1;
        mem_req_valid = 1'b0;
        mem_req_wr    = 1'b0;
        mem_req_addr  = 32'h0;
        mem_wr_data   = 32'h0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_ready", {31'd0, mem_req_ready}, 32'd0);
        check("reset_data", mem_req_data, 32'd0);
        check("reset_rd_count", rd_count, 32'd0);
        check("reset_wr_count", wr_count, 32'd0);
        check("reset_state", {30'd0, fsm_state}, 32'd0);

        // Table-driven transactions.
        for (int i = 0; i < 8; i++) begin
            run_txn(vecs[i].wr, vecs[i].addr, vecs[i].data, 1'b0, rdata);
            check($sformatf("vec%0d_data", i), rdata, vecs[i].exp_data);
            check($sformatf("vec%0d_rd_count", i), rd_count, vecs[i].exp_rd);
            check($sformatf("vec%0d_wr_count", i), wr_count, vecs[i].exp_wr);
        end

        // Reset in cycle 2 of a write: no ready pulse, nothing written, counters cleared.
        @(negedge clk);
        mem_req_valid = 1'b1;
        mem_req_wr    = 1'b1;
        mem_req_addr  = 32'h20;
        mem_wr_data   = 32'hAAAA_5555;
        repeat (2) @(negedge clk);
        rst           = 1'b1;
        mem_req_valid = 1'b0;
        mem_req_wr    = 1'b0;
        @(negedge clk);
        rst    = 1'b0;
        pulses = 0;
        repeat (8) begin
            @(negedge clk);
            if (mem_req_ready) pulses++;
        end
        check("rst_no_ready", pulses, 32'd0);
        check("rst_rd_count", rd_count, 32'd0);
        check("rst_wr_count", wr_count, 32'd0);
        check("rst_data", mem_req_data, 32'd0);
        run_txn(1'b0, 32'h20, 32'h0, 1'b0, rdata);
        check("rst_write_dropped", rdata, 32'h0);

        // Address, data and direction change during BUSY: captured values win.
        run_txn(1'b1, 32'h30, 32'h1, 1'b1, rdata);
        check("mut_wr_count", wr_count, 32'd1);
        check("mut_rd_count", rd_count, 32'd1);
        run_txn(1'b0, 32'h30, 32'h0, 1'b0, rdata);
        check("mut_mem30", rdata, 32'h1);
        run_txn(1'b0, 32'h40, 32'h0, 1'b0, rdata);
        check("mut_mem40", rdata, 32'h0);

        // Sixteen reads after a fresh reset; memory contents survive the reset.
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 16; i++) begin
            logic [31:0] e;
            case (i)
                0:       e = 32'hCAFE_F00D;
                1:       e = 32'h1234_5678;
                4:       e = 32'hDEAD_BEEF;
                12:      e = 32'h0000_0001;
                default: e = 32'h0;
            endcase
            run_txn(1'b0, 32'(i * 4), 32'h0, 1'b0, rdata);
            check($sformatf("seq%0d_data", i), rdata, e);
        end
        check("seq_rd_count", rd_count, 32'd16);
        check("seq_wr_count", wr_count, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
